// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin N:1 Wishbone arbiter that holds the grant for the owner's whole cycle.
// Define WB_RR_ARBITER_TIMEOUT_EN to add the stalled-slave bus-error timeout (TOERR state).
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_n_i,
   input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
   input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
   input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]    wbm_we_i,
   input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
   input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
   input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
   output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]    wbm_ack_o,
   output logic [NUM_MASTERS-1:0]    wbm_err_o,
   output logic [NUM_MASTERS-1:0]    wbm_rty_o,
   output logic [31:0]               wbs_adr_o,
   output logic [31:0]               wbs_dat_o,
   output logic [3:0]                wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [31:0]               wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i,
   output logic [NUM_MASTERS-1:0]    grant_o,
   output logic                      timeout_o
);
   localparam int IW = $clog2(NUM_MASTERS);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, BUSY, TOERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif
   state_t state, state_nxt;
   logic [IW-1:0] owner, last_owner, winner, idx;
   logic [31:0] adr [NUM_MASTERS];
   logic [31:0] dat [NUM_MASTERS];
   logic [3:0] sel [NUM_MASTERS];
   logic [2:0] cti [NUM_MASTERS];
   logic [1:0] bte [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] owner_oh;
   logic busy, idle, owner_cyc, owner_stb, resp, toerr, expire;
   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_slice
      assign adr[k] = wbm_adr_i[k*32 +: 32];
      assign dat[k] = wbm_dat_i[k*32 +: 32];
      assign sel[k] = wbm_sel_i[k*4 +: 4];
      assign cti[k] = wbm_cti_i[k*3 +: 3];
      assign bte[k] = wbm_bte_i[k*2 +: 2];
      assign wbm_dat_o[k*32 +: 32] = wbs_dat_i;
   end
   // Scanning downward lets the nearest requester above last_owner overwrite the others.
   always_comb begin
      winner = owner;
      idx = '0;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         idx = IW'((int'(last_owner) + i) % NUM_MASTERS);
         if (wbm_cyc_i[idx]) winner = idx;
      end
   end
   assign idle      = state == IDLE;
   assign busy      = state == BUSY;
   assign owner_oh  = NUM_MASTERS'(1) << owner;
   assign owner_cyc = wbm_cyc_i[owner];
   assign owner_stb = wbm_stb_i[owner];
   assign resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
   logic [15:0] cnt;
   logic stalled;
   assign stalled = busy && owner_cyc && owner_stb && !resp;
   assign expire  = stalled && (cnt + 16'd1 == 16'(TIMEOUT));
   assign toerr   = state == TOERR;
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
      if (!wb_rst_n_i) cnt <= '0;
      else cnt <= (stalled && !expire) ? cnt + 16'd1 : '0;
`else
   assign expire = 1'b0;
   assign toerr  = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      if (idle && |wbm_cyc_i) state_nxt = BUSY;
      else if (busy && !owner_cyc) state_nxt = IDLE;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      else if (busy && expire) state_nxt = TOERR;
      else if (toerr) state_nxt = BUSY;
`endif
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
      if (!wb_rst_n_i) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IW'(NUM_MASTERS - 1);
      end else begin
         state <= state_nxt;
         if (idle && |wbm_cyc_i) owner <= winner;
         if (busy && !owner_cyc) last_owner <= owner;
      end
   assign grant_o   = idle ? '0 : owner_oh;
   assign timeout_o = toerr;
   assign wbs_adr_o = adr[owner];
   assign wbs_dat_o = dat[owner];
   assign wbs_sel_o = sel[owner];
   assign wbs_we_o  = wbm_we_i[owner];
   assign wbs_cti_o = cti[owner];
   assign wbs_bte_o = bte[owner];
   assign wbs_cyc_o = busy && owner_cyc;
   assign wbs_stb_o = busy && owner_stb;
   assign wbm_ack_o = (busy && wbs_ack_i) ? owner_oh : '0;
   assign wbm_err_o = ((busy && wbs_err_i) || toerr) ? owner_oh : '0;
   assign wbm_rty_o = (busy && wbs_rty_i) ? owner_oh : '0;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus randomized traffic checked against a cycle-level arbitration model.
module tb_wb_rr_arbiter;
   localparam int N  = 3;
   localparam int TO = 4;
   logic clk = 0, rst_n = 0;
   logic [32*N-1:0] wbm_adr_i = '0, wbm_dat_i = '0, wbm_dat_o;
   logic [4*N-1:0] wbm_sel_i = '0;
   logic [N-1:0] wbm_we_i = '0, wbm_cyc_i = '0, wbm_stb_i = '0;
   logic [3*N-1:0] wbm_cti_i = '0;
   logic [2*N-1:0] wbm_bte_i = '0;
   logic [N-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
   logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i = '0;
   logic [3:0] wbs_sel_o;
   logic wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
   logic [2:0] wbs_cti_o;
   logic [1:0] wbs_bte_o;
   logic wbs_ack_i = 0, wbs_err_i = 0, wbs_rty_i = 0;
   int checks = 0, errors = 0;
   int m_owner = -1, m_last = N - 1, m_cnt = 0;
   bit m_toerr = 0;

   wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
      .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Advance one clock and apply the arbitration rules to the inputs that were present at that edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_owner = -1; m_last = N - 1; m_cnt = 0; m_toerr = 0;
      end else if (m_toerr) begin
         m_toerr = 0; m_cnt = 0;
      end else if (m_owner < 0) begin
         for (int i = N; i >= 1; i--) if (wbm_cyc_i[(m_last + i) % N]) m_owner = (m_last + i) % N;
      end else if (!wbm_cyc_i[m_owner]) begin
         m_last = m_owner; m_owner = -1; m_cnt = 0;
      end else if (wbm_stb_i[m_owner] && !(wbs_ack_i || wbs_err_i || wbs_rty_i)) begin
         m_cnt++;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
         if (m_cnt == TO) begin m_toerr = 1; m_cnt = 0; end
`endif
      end else m_cnt = 0;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      wbm_cyc_i = '0; wbm_stb_i = '0; wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; wbm_cyc_i = '1; wbm_stb_i = '1; wbs_ack_i = 1; wbs_err_i = 1; wbs_rty_i = 1;
      tick(); tick();
      checks++;
      if ({grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got grant=%b cyc=%b stb=%b ack=%b err=%b rty=%b to=%b want all 0", grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o);
      end
      clear_inputs(); rst_n = 1; tick();
   endtask

   task automatic test_simultaneous();
      for (int k = 0; k < N; k++) wbm_adr_i[k*32 +: 32] = 32'hA000_0000 + k;
      wbm_cyc_i = 3'b011; wbm_stb_i = 3'b011; #1;
      checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL simul_idle_grant: got %b want 000", grant_o); end
      tick();
      checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL simul_first_grant: got %b want 001", grant_o); end
      checks++; if ({wbs_cyc_o, wbs_adr_o} !== {1'b1, 32'hA000_0000}) begin errors++; $display("FAIL simul_route_m0: got cyc=%b adr=%h want 1 a0000000", wbs_cyc_o, wbs_adr_o); end
      wbm_cyc_i = 3'b010; wbm_stb_i = 3'b010; tick();
      checks++; if ({grant_o, wbs_cyc_o} !== 4'b0000) begin errors++; $display("FAIL simul_idle_gap: got grant=%b cyc=%b want 000 0", grant_o, wbs_cyc_o); end
      tick();
      checks++; if ({grant_o, wbs_adr_o} !== {3'b010, 32'hA000_0001}) begin errors++; $display("FAIL simul_second_grant: got grant=%b adr=%h want 010 a0000001", grant_o, wbs_adr_o); end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_burst();
      logic [2:0] cti;
      wbm_cyc_i = 3'b010; wbm_stb_i = 3'b010; tick();
      checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL burst_grant: got %b want 010", grant_o); end
      wbm_cyc_i = 3'b011; wbm_stb_i = 3'b011;
      for (int b = 0; b < 8; b++) begin
         cti = (b == 7) ? 3'b111 : 3'b010;
         wbm_cti_i[3 +: 3] = cti; wbs_ack_i = 1; wbs_dat_i = $urandom(); #1;
         checks++;
         if ({grant_o, wbm_ack_o, wbs_cti_o} !== {3'b010, 3'b010, cti}) begin
            errors++; $display("FAIL burst_beat%0d: got grant=%b ack=%b cti=%b want 010 010 %b", b, grant_o, wbm_ack_o, wbs_cti_o, cti);
         end
         tick();
      end
      wbs_ack_i = 0; wbm_cyc_i = 3'b001; wbm_stb_i = 3'b001; tick();
      checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL burst_gap: got %b want 000", grant_o); end
      tick();
      checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL burst_next_m0: got %b want 001", grant_o); end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_err_rty();
      wbm_cyc_i = 3'b100; wbm_stb_i = 3'b100; tick();
      wbs_err_i = 1; wbs_dat_i = $urandom(); #1;
      checks++;
      if ({wbm_err_o, wbm_ack_o, wbm_rty_o, wbm_dat_o} !== {3'b100, 6'b0, {N{wbs_dat_i}}}) begin
         errors++; $display("FAIL err_route: got err=%b ack=%b rty=%b dat=%h want 100 000 000 %h x3", wbm_err_o, wbm_ack_o, wbm_rty_o, wbm_dat_o, wbs_dat_i);
      end
      tick(); wbs_err_i = 0; wbs_rty_i = 1; wbs_dat_i = $urandom(); #1;
      checks++;
      if ({wbm_rty_o, wbm_ack_o, wbm_err_o, wbm_dat_o} !== {3'b100, 6'b0, {N{wbs_dat_i}}}) begin
         errors++; $display("FAIL rty_route: got rty=%b ack=%b err=%b dat=%h want 100 000 000 %h x3", wbm_rty_o, wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_dat_i);
      end
      tick(); clear_inputs(); tick(); tick();
   endtask

   task automatic test_stall();
      bit hit;
      wbm_cyc_i = 3'b001; wbm_stb_i = 3'b001; tick();
      for (int k = 1; k <= 12; k++) begin
`ifdef WB_RR_ARBITER_TIMEOUT_EN
         hit = (k % (TO + 1)) == 0;
`else
         hit = 0;
`endif
         checks++;
         if ({grant_o, timeout_o, wbs_stb_o, wbm_err_o} !== {3'b001, hit, !hit, hit ? 3'b001 : 3'b000}) begin
            errors++; $display("FAIL stall_cycle%0d: got grant=%b to=%b stb=%b err=%b want 001 %b %b %b", k, grant_o, timeout_o, wbs_stb_o, wbm_err_o, hit, !hit, hit ? 3'b001 : 3'b000);
         end
         tick();
      end
      clear_inputs(); tick(); tick();
      // A response on the would-be expiring cycle must win over the timeout.
      wbm_cyc_i = 3'b001; wbm_stb_i = 3'b001; tick();
      repeat (TO - 1) tick();
      wbs_ack_i = 1; #1;
      checks++; if (wbm_ack_o !== 3'b001) begin errors++; $display("FAIL stall_late_ack: got %b want 001", wbm_ack_o); end
      tick(); wbs_ack_i = 0; #1;
      checks++;
      if ({timeout_o, wbm_err_o, wbs_stb_o} !== 5'b0_000_1) begin
         errors++; $display("FAIL stall_ack_wins: got to=%b err=%b stb=%b want 0 000 1", timeout_o, wbm_err_o, wbs_stb_o);
      end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_async_reset();
      wbm_cyc_i = 3'b010; wbm_stb_i = 3'b010; tick(); tick();
      checks++; if ({grant_o, wbs_cyc_o} !== 4'b010_1) begin errors++; $display("FAIL areset_pre: got grant=%b cyc=%b want 010 1", grant_o, wbs_cyc_o); end
      wbs_ack_i = 1; #2; rst_n = 0; #1;
      checks++;
      if ({grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o} !== '0) begin
         errors++; $display("FAIL areset_async: got grant=%b cyc=%b stb=%b ack=%b want all 0", grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o);
      end
      tick();
      wbs_ack_i = 0; rst_n = 1; wbm_cyc_i = 3'b111; wbm_stb_i = 3'b111; #1;
      checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL areset_release: got %b want 000", grant_o); end
      tick();
      checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL areset_first_m0: got %b want 001", grant_o); end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_rr_order();
      int order[$];
      logic [N-1:0] drop = '0, prev = '0;
      rst_n = 0; tick(); rst_n = 1;
      for (int c = 0; c < 40; c++) begin
         wbm_cyc_i = ~drop; wbm_stb_i = ~drop; wbs_ack_i = 1; #1;
         if (grant_o != 0 && prev == 0)
            for (int k = 0; k < N; k++) if (grant_o[k]) order.push_back(k);
         prev = grant_o; drop = wbm_ack_o;
         tick();
      end
      checks++; if (order.size() < 6) begin errors++; $display("FAIL rr_grant_count: got %0d want >=6", order.size()); end
      for (int i = 0; i < 6 && i < order.size(); i++) begin
         checks++; if (order[i] != i % N) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], i % N); end
      end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_random();
      int o, r;
      bit busy;
      logic [N-1:0] oh;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 4) == 0) wbm_cyc_i[k] = ~wbm_cyc_i[k];
            wbm_stb_i[k] = wbm_cyc_i[k] && ($urandom_range(0, 3) != 0);
            wbm_adr_i[k*32 +: 32] = $urandom(); wbm_dat_i[k*32 +: 32] = $urandom();
            wbm_sel_i[k*4 +: 4] = 4'($urandom()); wbm_we_i[k] = 1'($urandom());
            wbm_cti_i[k*3 +: 3] = 3'($urandom()); wbm_bte_i[k*2 +: 2] = 2'($urandom());
         end
         r = $urandom_range(0, 9);
         wbs_ack_i = r < 4; wbs_err_i = r == 4; wbs_rty_i = r == 5; wbs_dat_i = $urandom(); #1;
         o = m_owner; busy = o >= 0 && !m_toerr;
         oh = (o >= 0) ? (N'(1) << o) : '0;
         checks++;
         if ({grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o, wbm_dat_o} !==
             {oh, busy && wbm_cyc_i[o < 0 ? 0 : o], busy && wbm_stb_i[o < 0 ? 0 : o],
              (busy && wbs_ack_i) ? oh : '0, (m_toerr || (busy && wbs_err_i)) ? oh : '0,
              (busy && wbs_rty_i) ? oh : '0, m_toerr, {N{wbs_dat_i}}}) begin
            errors++; $display("FAIL random_ctrl%0d: got grant=%b cyc=%b stb=%b ack=%b err=%b rty=%b to=%b want owner=%0d toerr=%b", c, grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o, o, m_toerr);
         end
         if (busy) begin
            checks++;
            if ({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o} !==
                {wbm_adr_i[o*32 +: 32], wbm_dat_i[o*32 +: 32], wbm_sel_i[o*4 +: 4], wbm_we_i[o], wbm_cti_i[o*3 +: 3], wbm_bte_i[o*2 +: 2]}) begin
               errors++; $display("FAIL random_data%0d: got adr=%h dat=%h sel=%h we=%b cti=%b bte=%b want slice of master %0d", c, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, o);
            end
         end
         tick();
      end
      clear_inputs(); tick(); tick();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_simultaneous();
      test_burst();
      test_err_rty();
      test_stall();
      test_async_reset();
      test_rr_order();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesting Wishbone masters (2..8).
REQ-002 Parameter TIMEOUT, default 255: stalled-cycle limit before bus error (1..65535).
REQ-003 Ports, in order:
- wb_clk_i, input, 1: single clock.
- wb_rst_n_i, input, 1: asynchronous, active-low reset.
REQ-004 Master-side ports; each field is flattened, with master k in slice k and master 0 in the LSBs:
- wbm_adr_i, input, 32*NUM_MASTERS.
- wbm_dat_i, input, 32*NUM_MASTERS.
- wbm_sel_i, input, 4*NUM_MASTERS.
- wbm_we_i, input, NUM_MASTERS.
- wbm_cyc_i, input, NUM_MASTERS.
- wbm_stb_i, input, NUM_MASTERS.
- wbm_cti_i, input, 3*NUM_MASTERS.
- wbm_bte_i, input, 2*NUM_MASTERS.
- wbm_dat_o, output, 32*NUM_MASTERS.
- wbm_ack_o, output, NUM_MASTERS.
- wbm_err_o, output, NUM_MASTERS.
- wbm_rty_o, output, NUM_MASTERS.
REQ-005 Slave-side ports:
- wbs_adr_o, output, 32.
- wbs_dat_o, output, 32.
- wbs_sel_o, output, 4.
- wbs_we_o, output, 1.
- wbs_cyc_o, output, 1.
- wbs_stb_o, output, 1.
- wbs_cti_o, output, 3.
- wbs_bte_o, output, 2.
- wbs_dat_i, input, 32.
- wbs_ack_i, input, 1.
- wbs_err_i, input, 1.
- wbs_rty_i, input, 1.
REQ-006 Status ports:
- grant_o, output, NUM_MASTERS: one-hot current owner; zero when idle.
- timeout_o, output, 1: one-cycle pulse per timeout event.

Function
REQ-007 The block SHALL implement states IDLE, BUSY and TOERR.
REQ-008 IDLE: if any wbm_cyc_i bit is set, the block SHALL register grant to the first requester found searching upward, with wrap-around, from last_owner+1, and enter BUSY on the next edge (1-cycle grant latency).
REQ-009 IDLE: grant_o SHALL be 0, wbs_cyc_o and wbs_stb_o SHALL be 0, and all wbm_ack_o/err_o/rty_o bits SHALL be 0.
REQ-010 BUSY slave outputs:
- wbs_adr_o, dat_o, sel_o, we_o, cti_o and bte_o SHALL combinationally follow the owner's slice.
- wbs_cyc_o and wbs_stb_o SHALL follow the owner's cyc/stb.
REQ-011 BUSY master outputs:
- wbs_ack_i, err_i and rty_i SHALL be routed only to the owner's bit; all other masters' bits SHALL be 0.
- wbs_dat_i SHALL be broadcast on every wbm_dat_o slice.
REQ-012 BUSY: the grant SHALL be held for the whole time the owner's wbm_cyc_i is high (bursts and RMW sequences are never split), regardless of other requests.
REQ-013 BUSY: when the owner's wbm_cyc_i falls, the block SHALL update last_owner to the owner and return to IDLE, leaving exactly one idle cycle between consecutive grants.
REQ-014 Requests that drop before being granted SHALL be ignored; no state is kept per non-owner.
REQ-015 If several requesters assert cyc in the same IDLE cycle, only the round-robin winner SHALL be granted; the losers wait without any response.

Reset
REQ-016 While wb_rst_n_i is low the block SHALL be in IDLE with last_owner = NUM_MASTERS-1 (master 0 wins first), the stall counter at 0, and grant_o, timeout_o and all wbs/wbm strobes and responses at 0.
REQ-017 Reset asserted mid-transfer SHALL immediately force wbs_cyc_o/stb_o low and drop the grant, with no response to the master.
REQ-018 Deassertion of reset SHALL take effect on the next rising edge of wb_clk_i.

Configuration
REQ-019 Macro WB_RR_ARBITER_TIMEOUT_EN SHALL select the bus-timeout feature.
REQ-020 With WB_RR_ARBITER_TIMEOUT_EN defined, the 16-bit stall counter SHALL:
- increment each BUSY cycle with owner stb high and no wbs_ack_i/err_i/rty_i;
- clear on any slave response, on stb low, and on leaving BUSY.
REQ-021 With WB_RR_ARBITER_TIMEOUT_EN defined, when the stall counter reaches TIMEOUT the block SHALL enter TOERR for one cycle, in which:
- wbs_cyc_o and wbs_stb_o are forced to 0;
- the owner's wbm_err_o is 1;
- timeout_o is 1.
It SHALL then return to BUSY with the counter at 0, grant unchanged.
REQ-022 If a slave response arrives in the same cycle the counter would reach TIMEOUT, the response SHALL win: no TOERR and the counter clears.
REQ-023 Without WB_RR_ARBITER_TIMEOUT_EN, no counter or TOERR state SHALL exist, timeout_o SHALL be tied to 0, and a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-024 Reset release, then m0 and m1 assert cyc in the same cycle -> grant_o=01 one cycle later; after m0 drops cyc, one idle cycle, then grant_o=10.
REQ-025 m1 owner runs an 8-beat burst (cti=010, final 111) while m0 requests -> all 8 acks go to m1, wbm_ack_o[0]=0 throughout, m0 is granted only after m1's cyc drops.
REQ-026 Slave responds with err, then with rty, to the owner -> only the owner's wbm_err_o/wbm_rty_o pulse, and all wbm_dat_o slices equal wbs_dat_i.
REQ-027 TIMEOUT_EN defined, TIMEOUT=4, slave never acks -> wbm_err_o[owner] and timeout_o pulse exactly once, with wbs_stb_o=0 in that same cycle, counting cycles from the first stalled one (excluded) through the 4th stalled one (included).
REQ-028 Transfer in progress, wb_rst_n_i pulsed low between clock edges -> wbs_cyc_o goes 0 asynchronously and grant_o=0; after release the next grant goes to master 0.
REQ-029 NUM_MASTERS=3, all masters requesting continuously with single-cycle transactions -> grant order 0,1,2,0,1,2.
